// File: rtl/soml_fixed_pkg.sv
// Fixed-point helpers shared by the SOML decoder datapath: default formats,
// a constant clog2 and a signed clamp to an n-bit two's complement range.
package soml_fixed_pkg;

    localparam int DEF_N = 16;
    localparam int DEF_Q = 8;
    localparam int ACC_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] x,
                                                          input int n);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/cplx_dot_seq_if.sv
// Operand buses, start/busy control and the valid/ready result channel
// of the sequenced complex dot-product engine.
interface cplx_dot_seq_if #(
    parameter int N     = 16,
    parameter int LANES = 4,
    parameter int NROW  = 2,
    parameter int NCOL  = 2
);
    localparam int RW = (NROW > 1) ? soml_fixed_pkg::clog2(NROW) : 1;
    localparam int CW = (NCOL > 1) ? soml_fixed_pkg::clog2(NCOL) : 1;

    logic                    start;
    logic [NROW*LANES*N-1:0] row_r;
    logic [NROW*LANES*N-1:0] row_i;
    logic [NCOL*LANES*N-1:0] col_r;
    logic [NCOL*LANES*N-1:0] col_i;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [N-1:0]            out_r;
    logic [N-1:0]            out_i;
    logic [RW-1:0]           out_row;
    logic [CW-1:0]           out_col;
    logic                    out_last;

    modport slave (
        input  start, row_r, row_i, col_r, col_i, out_ready,
        output busy, out_valid, out_r, out_i, out_row, out_col, out_last
    );

    modport master (
        output start, row_r, row_i, col_r, col_i, out_ready,
        input  busy, out_valid, out_r, out_i, out_row, out_col, out_last
    );

endinterface

// File: rtl/cdot_lane_mult.sv
// One lane of the complex multiply: full-precision products, registered
// after an arithmetic shift by Q (floor rounding). Holds while en_i is low.
module cdot_lane_mult #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic signed [N-1:0] ar_i,
    input  logic signed [N-1:0] ai_i,
    input  logic signed [N-1:0] br_i,
    input  logic signed [N-1:0] bi_i,
    output logic signed [2*N:0] pr_o,
    output logic signed [2*N:0] pi_o
);
    localparam int PW = 2 * N + 1;

    logic signed [PW-1:0] pr_s;
    logic signed [PW-1:0] pi_s;
    logic signed [PW-1:0] pr_q;
    logic signed [PW-1:0] pi_q;

    // Complex product at 2N+1 bits so the sum/difference cannot overflow.
    always_comb begin
        pr_s = (PW'(ar_i) * PW'(br_i)) - (PW'(ai_i) * PW'(bi_i));
        pi_s = (PW'(ar_i) * PW'(bi_i)) + (PW'(ai_i) * PW'(br_i));
    end

    // Product register with common pipeline hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q <= {PW{1'b0}};
            pi_q <= {PW{1'b0}};
        end else if (en_i) begin
            pr_q <= pr_s >>> Q;
            pi_q <= pi_s >>> Q;
        end
    end

    assign pr_o = pr_q;
    assign pi_o = pi_q;

endmodule

// File: rtl/cplx_dot_seq.sv
// Sequenced complex inner-product engine: walks all (row, column) pairs in
// row-major order through a 3-stage pipeline with valid/ready backpressure.
module cplx_dot_seq
    import soml_fixed_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int Q     = DEF_Q,
    parameter int LANES = 4,
    parameter int NROW  = 2,
    parameter int NCOL  = 2,
    parameter int SAT   = 1
) (
    input logic           clk,
    input logic           rst,
    cplx_dot_seq_if.slave bus
);
    localparam int RW = (NROW > 1) ? clog2(NROW) : 1;
    localparam int CW = (NCOL > 1) ? clog2(NCOL) : 1;
    localparam int PW = 2 * N + 1;
    localparam int SW = PW + clog2(LANES);
    localparam logic [RW-1:0] ROW_LAST = RW'(NROW - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);

    seq_state_e    state_q, state_d;
    logic          busy_q;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          en_s;
    logic          pair_last_s;
    logic          accept_last_s;

    logic signed [N-1:0] sel_ar_s [LANES];
    logic signed [N-1:0] sel_ai_s [LANES];
    logic signed [N-1:0] sel_br_s [LANES];
    logic signed [N-1:0] sel_bi_s [LANES];
    logic signed [N-1:0] s0_ar_q  [LANES];
    logic signed [N-1:0] s0_ai_q  [LANES];
    logic signed [N-1:0] s0_br_q  [LANES];
    logic signed [N-1:0] s0_bi_q  [LANES];
    logic                s0_v_q, s0_last_q;
    logic [RW-1:0]       s0_row_q;
    logic [CW-1:0]       s0_col_q;

    logic signed [PW-1:0] s1_pr_s [LANES];
    logic signed [PW-1:0] s1_pi_s [LANES];
    logic                 s1_v_q, s1_last_q;
    logic [RW-1:0]        s1_row_q;
    logic [CW-1:0]        s1_col_q;

    logic signed [SW-1:0]    sum_r_s, sum_i_s;
    logic signed [ACC_W-1:0] sat_r_s, sat_i_s;
    logic [ACC_W-N-1:0]      unused_r_hi_s, unused_i_hi_s;
    logic [N-1:0]            res_r_s, res_i_s;

    logic          out_valid_q, out_last_q;
    logic [N-1:0]  out_r_q, out_i_q;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    // A result held without ready freezes every stage and the pair counters.
    assign en_s          = !out_valid_q || bus.out_ready;
    assign pair_last_s   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign accept_last_s = out_valid_q && bus.out_ready && out_last_q;

    // Sequencer next state and pair counters (column fastest).
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    row_d   = {RW{1'b0}};
                    col_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (en_s) begin
                    if (pair_last_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = {CW{1'b0}};
                        if (row_q == ROW_LAST) begin
                            row_d = {RW{1'b0}};
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (accept_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            row_q   <= {RW{1'b0}};
            col_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Operand select for the current pair.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            sel_ar_s[k] = bus.row_r[(int'(row_q) * LANES + k) * N +: N];
            sel_ai_s[k] = bus.row_i[(int'(row_q) * LANES + k) * N +: N];
            sel_br_s[k] = bus.col_r[(int'(col_q) * LANES + k) * N +: N];
            sel_bi_s[k] = bus.col_i[(int'(col_q) * LANES + k) * N +: N];
        end
    end

    // S0: registered operands and pair tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_v_q    <= 1'b0;
            s0_last_q <= 1'b0;
            s0_row_q  <= {RW{1'b0}};
            s0_col_q  <= {CW{1'b0}};
            for (int k = 0; k < LANES; k++) begin
                s0_ar_q[k] <= {N{1'b0}};
                s0_ai_q[k] <= {N{1'b0}};
                s0_br_q[k] <= {N{1'b0}};
                s0_bi_q[k] <= {N{1'b0}};
            end
        end else if (en_s) begin
            s0_v_q    <= (state_q == ST_RUN);
            s0_last_q <= pair_last_s;
            s0_row_q  <= row_q;
            s0_col_q  <= col_q;
            for (int k = 0; k < LANES; k++) begin
                s0_ar_q[k] <= sel_ar_s[k];
                s0_ai_q[k] <= sel_ai_s[k];
                s0_br_q[k] <= sel_br_s[k];
                s0_bi_q[k] <= sel_bi_s[k];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        cdot_lane_mult #(.N(N), .Q(Q)) u_mult (
            .clk   (clk),
            .rst_n (rst),
            .en_i  (en_s),
            .ar_i  (s0_ar_q[g]),
            .ai_i  (s0_ai_q[g]),
            .br_i  (s0_br_q[g]),
            .bi_i  (s0_bi_q[g]),
            .pr_o  (s1_pr_s[g]),
            .pi_o  (s1_pi_s[g])
        );
    end

    // S1: pair tag travelling alongside the lane products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_row_q  <= {RW{1'b0}};
            s1_col_q  <= {CW{1'b0}};
        end else if (en_s) begin
            s1_v_q    <= s0_v_q;
            s1_last_q <= s0_last_q;
            s1_row_q  <= s0_row_q;
            s1_col_q  <= s0_col_q;
        end
    end

    // Lane sum at full width, then clamp or wrap to N bits.
    always_comb begin
        sum_r_s = {SW{1'b0}};
        sum_i_s = {SW{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            sum_r_s = sum_r_s + SW'(s1_pr_s[k]);
            sum_i_s = sum_i_s + SW'(s1_pi_s[k]);
        end
        if (SAT != 0) begin
            sat_r_s = saturate(ACC_W'(sum_r_s), N);
            sat_i_s = saturate(ACC_W'(sum_i_s), N);
        end else begin
            sat_r_s = ACC_W'(sum_r_s);
            sat_i_s = ACC_W'(sum_i_s);
        end
        res_r_s       = sat_r_s[N-1:0];
        res_i_s       = sat_i_s[N-1:0];
        unused_r_hi_s = sat_r_s[ACC_W-1:N];
        unused_i_hi_s = sat_i_s[ACC_W-1:N];
    end

    // S2: result register driving the output channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= {N{1'b0}};
            out_i_q     <= {N{1'b0}};
            out_row_q   <= {RW{1'b0}};
            out_col_q   <= {CW{1'b0}};
        end else if (en_s) begin
            out_valid_q <= s1_v_q;
            out_last_q  <= s1_last_q;
            out_r_q     <= res_r_s;
            out_i_q     <= res_i_s;
            out_row_q   <= s1_row_q;
            out_col_q   <= s1_col_q;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_i     = out_i_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;

endmodule
